// File: rtl/axi_pack_conv_r_pack.sv
// ---------------------------------------------------------------------------
// axi_pack_conv_r_pack
//
// Read-data packer of the AXI pack converter. Every memory-side R beat that
// arrives here carries exactly one element (one element read issued by the
// AX converter). The matching SARQ entry tells where that element sits in the
// memory beat, how wide it is and whether it ends the SSR burst. Elements are
// extracted and packed densely into DataWidth_O-wide SSR R beats. Beat
// framing comes from the SARQ only. The response of each SSR beat is the
// worst response of the elements that were packed into it.
//
// Ports
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   r_chan_i     : memory R beat (id and last are ignored)
//   r_valid_i    : memory R valid
//   r_ready_o    : memory R ready (combinational, depends on r_ready_i)
//   sarq_i       : head of the SARQ FIFO (id, size, offset, last)
//   sarq_empty_i : SARQ empty
//   sarq_pop_o   : pop the SARQ head (one per consumed element)
//   r_chan_o     : packed SSR R beat (registered)
//   r_valid_o    : SSR R valid (registered)
//   r_ready_i    : SSR R ready
// ---------------------------------------------------------------------------

package axi_pack_conv_r_pack_pkg;

    // Default channel types for DataWidth_I=64, DataWidth_O=32, AxiIdWidth=4.
    // Integrations with other widths pass their own struct types.
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } ssr_r_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [2:0] size;    // log2 of element bytes
        logic [2:0] offset;  // byte offset in the memory beat
        logic       last;    // final element of the SSR burst
    } sarq_t;

endpackage

module axi_pack_conv_r_pack
    import axi_pack_conv_r_pack_pkg::*;
#(
    parameter int unsigned DataWidth_I      = 64,
    parameter int unsigned DataWidth_O      = 32,
    parameter int unsigned AxiIdWidth       = 4,
    parameter type         axi_r_chan_t     = r_chan_t,
    parameter type         axi_ssr_r_chan_t = ssr_r_chan_t,
    parameter type         sarq_t           = axi_pack_conv_r_pack_pkg::sarq_t
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  axi_r_chan_t     r_chan_i,
    input  logic            r_valid_i,
    output logic            r_ready_o,
    input  sarq_t           sarq_i,
    input  logic            sarq_empty_i,
    output logic            sarq_pop_o,
    output axi_ssr_r_chan_t r_chan_o,
    output logic            r_valid_o,
    input  logic            r_ready_i
);

    localparam int unsigned BytesI = DataWidth_I / 8;
    localparam int unsigned BytesO = DataWidth_O / 8;
    localparam int unsigned OffW   = (BytesI > 1) ? $clog2(BytesI) : 1;
    localparam int unsigned PosW   = $clog2(BytesO) + 1;

    localparam logic [2:0] MaxSize = 3'($clog2(BytesO));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DataWidth_O-1:0] acc_q;      // bytes packed so far
    logic [PosW-1:0]        pos_q;      // next free byte slot in acc_q
    logic [1:0]             resp_q;     // worst response packed so far
    axi_ssr_r_chan_t        out_q;      // SSR beat on offer
    logic                   out_valid_q;

    // ------------------------------------------------------------------
    // Element decode and extraction
    // ------------------------------------------------------------------
    logic [PosW-1:0]        eb;         // element bytes
    logic [OffW-1:0]        off;        // offset aligned down to eb
    logic [DataWidth_I-1:0] shifted;
    logic [DataWidth_O-1:0] elem_mask;
    logic [DataWidth_O-1:0] elem;
    logic [DataWidth_O-1:0] placed;
    logic [DataWidth_O-1:0] data_merged;
    logic [PosW:0]          pos_sum;
    logic [1:0]             resp_merged;
    logic                   fill_beat;
    logic                   close;
    logic                   slot_free;
    logic                   take;

    assign eb = PosW'(1) << sarq_i.size;

    // Force-align the offset: a misaligned request still reads the element
    // whose aligned slot contains the given byte.
    assign off = sarq_i.offset & ~(OffW'(eb) - OffW'(1));

    assign shifted = r_chan_i.data >> {off, 3'b000};

    // NOTE: every signal driven from always_comb gets a value before any
    // conditional logic, otherwise a synthesis tool infers a latch.
    always_comb begin
        elem_mask = '0;
        for (int unsigned b = 0; b < BytesO; b++) begin
            if (b < 32'(eb)) begin
                elem_mask[8*b +: 8] = 8'hFF;
            end
        end
    end

    assign elem        = shifted[DataWidth_O-1:0] & elem_mask;
    assign placed      = elem << {pos_q, 3'b000};
    assign data_merged = acc_q | placed;

    // One extra bit so a corrupt size cannot wrap the comparison.
    assign pos_sum   = {1'b0, pos_q} + {1'b0, eb};
    assign fill_beat = (pos_sum == (PosW+1)'(BytesO));

    // AXI responses are ordered by severity (OKAY < EXOKAY < SLVERR <
    // DECERR), so the numeric maximum is the merged response.
    assign resp_merged = (r_chan_i.resp > resp_q) ? r_chan_i.resp : resp_q;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // A closing element needs the output register: it may go if the register
    // is empty or is being drained this cycle. Non-closing elements only
    // touch the accumulator and are never held back by the SSR side.
    assign close     = sarq_i.last | fill_beat;
    assign slot_free = ~close | ~out_valid_q | r_ready_i;

    assign r_ready_o  = ~sarq_empty_i & slot_free;
    assign take       = r_valid_i & r_ready_o;
    assign sarq_pop_o = take;

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            pos_q  <= '0;
            resp_q <= '0;
        end else if (take) begin
            if (close) begin
                acc_q  <= '0;
                pos_q  <= '0;
                resp_q <= '0;
            end else begin
                acc_q  <= data_merged;
                pos_q  <= pos_sum[PosW-1:0];
                resp_q <= resp_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    axi_ssr_r_chan_t out_d;

    always_comb begin
        out_d      = '0;
        out_d.id   = sarq_i.id;
        out_d.data = data_merged;
        out_d.resp = resp_merged;
        out_d.last = sarq_i.last;
    end

    // The register is loaded only by a closing take, and a closing take is
    // blocked while the beat is stalled, so a stalled beat never changes.
    // Loading while the old beat is popped gives back-to-back beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (take && close) begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
        end else if (r_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign r_chan_o  = out_q;
    assign r_valid_o = out_valid_q;

    // Memory-side id/last carry no information here; framing is the SARQ's.
    logic unused_bits;
    assign unused_bits = ^{r_chan_i.id, r_chan_i.last,
                           shifted[DataWidth_I-1:DataWidth_O]};

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_size_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid_i && !sarq_empty_i) |-> (sarq_i.size <= MaxSize));

    a_out_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid_o && !r_ready_i) |=> (r_valid_o && $stable(r_chan_o)));

endmodule
